// File: rtl/ram_wr_sched_if.sv
// Bundle of requester-side handshake and RAM write-port signals for ram_wr_sched.
// The scheduler is the slave; requesters and the RAM side together form the master.
interface ram_wr_sched_if #(
  parameter int SZ    = 2,
  parameter int DW    = 32,
  parameter int RQCNT = 4
);
  localparam int AW = (SZ > 1) ? $clog2(SZ) : 1;

  logic                  busy_o;
  logic [RQCNT-1:0]      req_i;
  logic [RQCNT*AW-1:0]   addr_i;
  logic [RQCNT*DW-1:0]   data_i;
  logic [RQCNT-1:0]      ack_o;
  logic                  we_o;
  logic [AW-1:0]         addr_o;
  logic [DW-1:0]         data_o;

  modport master (
    input  busy_o, ack_o, we_o, addr_o, data_o,
    output req_i, addr_i, data_i
  );

  modport slave (
    input  req_i, addr_i, data_i,
    output busy_o, ack_o, we_o, addr_o, data_o
  );
endinterface

// File: rtl/ram_wr_sched.sv
// Round-robin scheduler for the single write port of a multi-read-port RAM.
// Define RAM_WR_SCHED_CLR_EN to build the post-reset clear sequencer (writes INITVAL to every word).
//
// state | meaning
// CLR   | clear sequencer walking addresses 0..SZ-1, no grants
// RUN   | round-robin arbitration of requesters onto the write port
module ram_wr_sched #(
  parameter int            SZ      = 2,
  parameter int            DW      = 32,
  parameter int            RQCNT   = 4,
  parameter logic [DW-1:0] INITVAL = '0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  ram_wr_sched_if.slave  bus
);
  localparam int AW = (SZ > 1) ? $clog2(SZ) : 1;
  localparam int PW = $clog2(RQCNT);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          found;
  logic          grant;
  logic          run;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] data_r;

`ifdef RAM_WR_SCHED_CLR_EN
  localparam int CW = $clog2(SZ) + 1;

  typedef enum logic {CLR, RUN} state_t;
  state_t        state;
  logic [CW-1:0] cnt;

  assign run        = (state == RUN);
  assign bus.busy_o = (state == CLR);
`else
  logic unused_initval;

  assign run            = 1'b1;
  assign bus.busy_o     = 1'b0;
  assign unused_initval = ^INITVAL;
`endif

  // Search starts one past the last winner and wraps, so a repeat winner waits for everyone else.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= RQCNT; i++) begin
      idx = PW'((int'(ptr) + i) % RQCNT);
      if (!found && bus.req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign grant      = found & run;
  assign bus.ack_o  = grant ? (RQCNT'(1) << win) : '0;
  assign bus.we_o   = we_r;
  assign bus.addr_o = addr_r;
  assign bus.data_o = data_r;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
`ifdef RAM_WR_SCHED_CLR_EN
      state <= CLR;
      cnt   <= '0;
`endif
      ptr    <= PW'(RQCNT - 1);
      we_r   <= 1'b0;
      addr_r <= '0;
      data_r <= '0;
    end
`ifdef RAM_WR_SCHED_CLR_EN
    else if (state == CLR) begin
      we_r   <= 1'b1;
      addr_r <= cnt[AW-1:0];
      data_r <= INITVAL;
      cnt    <= cnt + CW'(1);
      if (cnt == CW'(SZ - 1))
        state <= RUN;
    end
`endif
    else if (grant) begin
      we_r   <= 1'b1;
      addr_r <= bus.addr_i[int'(win)*AW +: AW];
      data_r <= bus.data_i[int'(win)*DW +: DW];
      ptr    <= win;
    end else begin
      we_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ram_wr_sched.sv
// Directed bench for ram_wr_sched: reset, round-robin order, latency, pointer wrap, reset drop.
// Clear-sequencer checks are active when RAM_WR_SCHED_CLR_EN is defined for the build.
module tb_ram_wr_sched;
  localparam int            SZ      = 8;
  localparam int            DW      = 32;
  localparam int            RQCNT   = 4;
  localparam int            AW      = 3;
  localparam logic [DW-1:0] INITVAL = 32'hDEADBEEF;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  ram_wr_sched_if #(.SZ(SZ), .DW(DW), .RQCNT(RQCNT)) bus ();

  ram_wr_sched #(.SZ(SZ), .DW(DW), .RQCNT(RQCNT), .INITVAL(INITVAL)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_slot(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.addr_i[k*AW +: AW] = a;
    bus.data_i[k*DW +: DW] = d;
  endtask

  // Runs up to n clear cycles from reset release, checking busy, no ack and the written words.
  task automatic clr_seq(input int n);
    bus.req_i = 4'b1111;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("clr_busy", 32'(bus.busy_o), 32'd1);
      chk("clr_ack", 32'(bus.ack_o), 32'd0);
      cyc();
      chk("clr_we", 32'(bus.we_o), 32'd1);
      chk("clr_addr", 32'(bus.addr_o), 32'(i));
      chk("clr_data", bus.data_o, INITVAL);
    end
    if (n == SZ) begin
      bus.req_i = 4'b0000;
      #1;
      chk("clr_done_busy", 32'(bus.busy_o), 32'd0);
      cyc();
      chk("clr_done_we", 32'(bus.we_o), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_i     = 1'b0;
    bus.req_i = '0;
    cyc();
    cyc();
    rst_i = 1'b1;
`ifdef RAM_WR_SCHED_CLR_EN
    clr_seq(SZ);
`endif
  endtask

  initial begin
    logic [3:0] exp_ack;
    int         k;

    bus.req_i  = '0;
    bus.addr_i = '0;
    bus.data_i = '0;

    rst_i = 1'b0;
    cyc();
    cyc();
`ifdef RAM_WR_SCHED_CLR_EN
    chk("rst_busy", 32'(bus.busy_o), 32'd1);
`else
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
`endif
    chk("rst_we", 32'(bus.we_o), 32'd0);
    chk("rst_addr", 32'(bus.addr_o), 32'd0);
    chk("rst_data", bus.data_o, 32'd0);
    rst_i = 1'b1;

`ifdef RAM_WR_SCHED_CLR_EN
    clr_seq(3);
    rst_i = 1'b0;
    cyc();
    chk("midclr_rst_we", 32'(bus.we_o), 32'd0);
    chk("midclr_rst_addr", 32'(bus.addr_o), 32'd0);
    rst_i = 1'b1;
    clr_seq(SZ);
`else
    set_slot(0, 3'd5, 32'h12345678);
    bus.req_i = 4'b0001;
    #1;
    chk("first_busy", 32'(bus.busy_o), 32'd0);
    chk("first_ack", 32'(bus.ack_o), 32'h1);
    cyc();
    bus.req_i = '0;
    chk("first_we", 32'(bus.we_o), 32'd1);
    chk("first_addr", 32'(bus.addr_o), 32'd5);
    chk("first_data", bus.data_o, 32'h12345678);
`endif

    // all four requesting; each acked requester drops for one cycle
    do_reset();
    for (int i = 0; i < RQCNT; i++)
      set_slot(i, AW'(7 - i), 32'h11111111 * (i + 1));
    bus.req_i = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      k       = j % RQCNT;
      exp_ack = 4'b0001 << k;
      #1;
      chk("rr_ack", 32'(bus.ack_o), 32'(exp_ack));
      cyc();
      bus.req_i = 4'b1111 & ~exp_ack;
      chk("rr_we", 32'(bus.we_o), 32'd1);
      chk("rr_addr", 32'(bus.addr_o), 32'(7 - k));
      chk("rr_data", bus.data_o, 32'h11111111 * (k + 1));
    end
    bus.req_i = '0;
    #1;
    chk("rr_idle_ack", 32'(bus.ack_o), 32'd0);
    cyc();
    chk("rr_idle_we", 32'(bus.we_o), 32'd0);
    chk("rr_idle_addr", 32'(bus.addr_o), 32'd4);

    // single requester 2
    set_slot(2, 3'd3, 32'h55);
    bus.req_i = 4'b0100;
    #1;
    chk("one_ack", 32'(bus.ack_o), 32'h4);
    cyc();
    bus.req_i = '0;
    chk("one_we", 32'(bus.we_o), 32'd1);
    chk("one_addr", 32'(bus.addr_o), 32'd3);
    chk("one_data", bus.data_o, 32'h55);
    cyc();
    chk("one_we_off", 32'(bus.we_o), 32'd0);
    chk("one_addr_hold", 32'(bus.addr_o), 32'd3);
    chk("one_data_hold", bus.data_o, 32'h55);

    // ptr=1 then 0011: search starts at 2 and wraps to 0
    bus.req_i = 4'b0010;
    #1;
    chk("p1_ack", 32'(bus.ack_o), 32'h2);
    cyc();
    bus.req_i = 4'b0011;
    #1;
    chk("wrap_ack0", 32'(bus.ack_o), 32'h1);
    cyc();
    bus.req_i = 4'b0010;
    chk("wrap_addr0", 32'(bus.addr_o), 32'd7);
    #1;
    chk("wrap_ack1", 32'(bus.ack_o), 32'h2);
    cyc();
    chk("wrap_addr1", 32'(bus.addr_o), 32'd6);
    bus.req_i = '0;
    cyc();
    cyc();
    bus.req_i = 4'b0011;
    #1;
    chk("idle_keeps_ptr", 32'(bus.ack_o), 32'h1);

    // reset on the granting edge drops the write
    rst_i = 1'b0;
    cyc();
    chk("rst_drop_we", 32'(bus.we_o), 32'd0);
    bus.req_i = '0;
    rst_i     = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
